// File: rtl/nn_pkg.sv
// Shared types and defaults for the activation backward-pass blocks.
package nn_pkg;
    localparam int NN_WIDTH = 16;
    localparam int NN_DIM   = 1;

    typedef logic signed [NN_WIDTH-1:0] elem_t;
    typedef logic [NN_DIM-1:0]          mask_t;

    // Strictly positive test; zero maps to 0 so the derivative at 0 is 0.
    function automatic logic is_pos(input elem_t e);
        return !e[NN_WIDTH-1] && (e != '0);
    endfunction
endpackage

// File: rtl/mask_fifo.sv
// DEPTH-deep, W-bit-wide synchronous FIFO with full/empty/count and sync clear.
module mask_fifo
    import nn_pkg::*;
#(
    parameter int W     = NN_DIM,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/relu_backward.sv
// ReLU backward pass: stores forward "was positive" masks, gates upstream gradients.
// Define RELU_BWD_LEAKY_EN to pass masked elements as grad >>> LEAK_SHIFT instead of 0.
module relu_backward
    import nn_pkg::*;
#(
    parameter int DIM        = NN_DIM,
    parameter int WIDTH      = NN_WIDTH,
    parameter int DEPTH      = 8,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   fwd_valid,
    output logic                   fwd_ready,
    input  logic [DIM*WIDTH-1:0]   fwd_vec,
    input  logic                   grad_valid,
    output logic                   grad_ready,
    input  logic [DIM*WIDTH-1:0]   grad_vec,
    output logic                   gout_valid,
    input  logic                   gout_ready,
    output logic [DIM*WIDTH-1:0]   gout_vec,
    output logic [$clog2(DEPTH):0] mask_count
);
    logic [DIM-1:0]       fwd_mask, pop_mask;
    logic [DIM*WIDTH-1:0] gated;
    logic                 full, empty, accept;

    assign fwd_ready  = !full;
    assign grad_ready = !empty && (!gout_valid || gout_ready);
    assign accept     = grad_valid && grad_ready;

    mask_fifo #(.W(DIM), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (fwd_valid),
        .din   (fwd_mask),
        .pop   (accept),
        .dout  (pop_mask),
        .full  (full),
        .empty (empty),
        .count (mask_count)
    );

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        logic signed [WIDTH-1:0] f, g, leak;
        assign f = fwd_vec[i*WIDTH +: WIDTH];
        assign g = grad_vec[i*WIDTH +: WIDTH];
        assign fwd_mask[i] = !f[WIDTH-1] && (f != '0);
`ifdef RELU_BWD_LEAKY_EN
        assign leak = g >>> LEAK_SHIFT;
`else
        assign leak = '0;
`endif
        assign gated[i*WIDTH +: WIDTH] = pop_mask[i] ? g : leak;
    end

    // Single-entry output stage; holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gout_valid <= 1'b0;
            gout_vec   <= '0;
        end else if (clr) begin
            gout_valid <= 1'b0;
            gout_vec   <= '0;
        end else if (accept) begin
            gout_valid <= 1'b1;
            gout_vec   <= gated;
        end else if (gout_ready) begin
            gout_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_relu_backward.sv
// Self-checking bench for relu_backward (DIM=4, WIDTH=16, DEPTH=8) with output scoreboard.
module tb_relu_backward;
    localparam int DIM = 4, WIDTH = 16, DEPTH = 8, LS = 3;
    localparam int VW = DIM * WIDTH;

    logic clk = 0, rst_n = 0, clr = 0;
    logic fwd_valid = 0, grad_valid = 0, gout_ready = 1;
    logic fwd_ready, grad_ready, gout_valid;
    logic [VW-1:0] fwd_vec = '0, grad_vec = '0, gout_vec;
    logic [$clog2(DEPTH):0] mask_count;

    int checks = 0, failures = 0;

    logic [DIM-1:0] mq[$];
    logic [VW-1:0]  eq[$];
    logic           m_gv = 0;

    relu_backward #(.DIM(DIM), .WIDTH(WIDTH), .DEPTH(DEPTH), .LEAK_SHIFT(LS)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_vec(fwd_vec),
        .grad_valid(grad_valid), .grad_ready(grad_ready), .grad_vec(grad_vec),
        .gout_valid(gout_valid), .gout_ready(gout_ready), .gout_vec(gout_vec),
        .mask_count(mask_count)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] pack(input int a, input int b, input int c, input int d);
        logic [VW-1:0] v;
        v[0*WIDTH +: WIDTH] = 16'(a);
        v[1*WIDTH +: WIDTH] = 16'(b);
        v[2*WIDTH +: WIDTH] = 16'(c);
        v[3*WIDTH +: WIDTH] = 16'(d);
        return v;
    endfunction

    function automatic logic [DIM-1:0] mask_of(input logic [VW-1:0] v);
        logic [DIM-1:0] m;
        for (int i = 0; i < DIM; i++) begin
            logic signed [WIDTH-1:0] e;
            e = v[i*WIDTH +: WIDTH];
            m[i] = (e > 0);
        end
        return m;
    endfunction

    function automatic logic [VW-1:0] gate(input logic [DIM-1:0] m, input logic [VW-1:0] g);
        logic [VW-1:0] r;
        for (int i = 0; i < DIM; i++) begin
            logic signed [WIDTH-1:0] e;
            e = g[i*WIDTH +: WIDTH];
`ifdef RELU_BWD_LEAKY_EN
            r[i*WIDTH +: WIDTH] = m[i] ? e : (e >>> LS);
`else
            r[i*WIDTH +: WIDTH] = m[i] ? e : '0;
`endif
        end
        return r;
    endfunction

    // Reference model + scoreboard, evaluated mid-cycle while inputs are stable.
    always @(negedge clk) begin
        logic exp_fr, exp_gr;
        logic [VW-1:0] exp_v;
        if (!rst_n) begin
            mq.delete(); eq.delete(); m_gv = 0;
            checks++;
            if (gout_valid !== 1'b0 || mask_count !== '0) begin
                failures++;
                $display("FAIL reset_outputs gout_valid=%0b mask_count=%0d required 0/0", gout_valid, mask_count);
            end
        end else begin
            exp_fr = (mq.size() < DEPTH);
            exp_gr = (mq.size() > 0) && (!m_gv || gout_ready);
            checks++;
            if (fwd_ready !== exp_fr || grad_ready !== exp_gr || gout_valid !== m_gv ||
                mask_count !== ($clog2(DEPTH)+1)'(mq.size())) begin
                failures++;
                $display("FAIL handshake fr=%0b gr=%0b gv=%0b cnt=%0d required fr=%0b gr=%0b gv=%0b cnt=%0d",
                         fwd_ready, grad_ready, gout_valid, mask_count, exp_fr, exp_gr, m_gv, mq.size());
            end
            if (m_gv && gout_ready) begin
                checks++;
                if (eq.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_underflow got=%h", gout_vec);
                end else begin
                    exp_v = eq.pop_front();
                    if (gout_vec !== exp_v) begin
                        failures++;
                        $display("FAIL gout_vec got=%h required=%h", gout_vec, exp_v);
                    end
                end
            end
            if (clr) begin
                mq.delete(); eq.delete(); m_gv = 0;
            end else begin
                if (grad_valid && exp_gr) begin
                    eq.push_back(gate(mq.pop_front(), grad_vec));
                    m_gv = 1;
                end else if (gout_ready) begin
                    m_gv = 0;
                end
                if (fwd_valid && exp_fr) mq.push_back(mask_of(fwd_vec));
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        fwd_valid = 0; grad_valid = 0; clr = 0; gout_ready = 1;
    endtask

    task automatic drain();
        idle();
        grad_valid = 1;
        for (int i = 0; i < 2*DEPTH + 2; i++) step();
        grad_valid = 0;
        step(); step();
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++;
        if (gout_vec !== '0 || fwd_ready !== 1'b1 || grad_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_state gout_vec=%h fr=%0b gr=%0b required 0/1/0", gout_vec, fwd_ready, grad_ready);
        end
        step(); rst_n = 1; step();
    endtask

    task automatic test_basic();
        logic [VW-1:0] exp;
`ifdef RELU_BWD_LEAKY_EN
        exp = pack(12, 25, -300, -1);
`else
        exp = pack(0, 0, -300, -1);
`endif
        fwd_vec = pack(-5, 0, 7, 32767); fwd_valid = 1; step();
        fwd_valid = 0; grad_vec = pack(100, 200, -300, -1); grad_valid = 1; step();
        grad_valid = 0;
        @(negedge clk);
        checks++;
        if (gout_valid !== 1'b1 || gout_vec !== exp) begin
            failures++;
            $display("FAIL basic_gating gv=%0b got=%h required=%h", gout_valid, gout_vec, exp);
        end
        step(); step();
    endtask

    task automatic test_backpressure();
        int n = 0;
        gout_ready = 0;
        for (int i = 0; i < 3; i++) begin
            fwd_vec = pack(i == 0 ? 1 : -1, i == 1 ? 1 : -1, i == 2 ? 1 : -1, 5); fwd_valid = 1; step();
        end
        fwd_valid = 0;
        grad_vec = pack(11, 22, 33, 44); grad_valid = 1; step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (gout_valid !== 1'b1 || gout_vec !== gate(4'b1001, pack(11, 22, 33, 44)) || grad_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold gv=%0b got=%h gr=%0b", gout_valid, gout_vec, grad_ready);
            end
            step();
        end
        n = 1; gout_ready = 1;
        for (int t = 0; t < 20 && n < 3; t++) begin
            grad_vec = pack(11 + n, 22 + n, 33 + n, 44 + n);
            @(negedge clk);
            if (grad_ready) n++;
            step();
        end
        grad_valid = 0;
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL backpressure_timeout accepted=%0d required 3", n);
        end
        step(); step();
    endtask

    task automatic test_full_empty();
        grad_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (grad_ready !== 1'b0 || gout_valid !== 1'b0) begin
                failures++;
                $display("FAIL empty_grad gr=%0b gv=%0b required 0/0", grad_ready, gout_valid);
            end
            step();
        end
        grad_valid = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            fwd_vec = pack(i - 3, 3 - i, i, -i); fwd_valid = 1; step();
        end
        fwd_valid = 0;
        @(negedge clk);
        checks++;
        if (fwd_ready !== 1'b0 || mask_count !== 4'd8) begin
            failures++;
            $display("FAIL full fr=%0b cnt=%0d required 0/8", fwd_ready, mask_count);
        end
        step();
        drain();
        fwd_vec = pack(9, -9, 9, -9); fwd_valid = 1; grad_vec = pack(7, 7, 7, 7); grad_valid = 1;
        @(negedge clk);
        checks++;
        if (grad_ready !== 1'b0) begin
            failures++;
            $display("FAIL no_bypass gr=%0b required 0", grad_ready);
        end
        step(); fwd_valid = 0;
        @(negedge clk);
        checks++;
        if (grad_ready !== 1'b1) begin
            failures++;
            $display("FAIL push_then_pop gr=%0b required 1", grad_ready);
        end
        step(); grad_valid = 0; step(); step();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) begin
            fwd_vec = VW'({$urandom, $urandom}); fwd_valid = 1; step();
        end
        for (int i = 0; i < 20; i++) begin
            fwd_vec = VW'({$urandom, $urandom}); grad_vec = VW'({$urandom, $urandom});
            fwd_valid = 1; grad_valid = 1;
            @(negedge clk);
            checks++;
            if (mask_count !== 4'd4) begin
                failures++;
                $display("FAIL wrap_count cnt=%0d required 4", mask_count);
            end
            step();
        end
        drain();
    endtask

    task automatic test_clr_reset();
        for (int i = 0; i < 6; i++) begin
            fwd_vec = pack(i, -i, 1, 1); fwd_valid = 1; step();
        end
        fwd_valid = 0; gout_ready = 0; grad_vec = pack(1, 2, 3, 4); grad_valid = 1; step();
        grad_valid = 0;
        @(negedge clk);
        checks++;
        if (mask_count !== 4'd5 || gout_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_clr cnt=%0d gv=%0b required 5/1", mask_count, gout_valid);
        end
        step(); clr = 1; step(); clr = 0;
        @(negedge clk);
        checks++;
        if (mask_count !== '0 || gout_valid !== 1'b0) begin
            failures++;
            $display("FAIL clr cnt=%0d gv=%0b required 0/0", mask_count, gout_valid);
        end
        step(); gout_ready = 1;
        for (int i = 0; i < 3; i++) begin
            fwd_vec = pack(5, 5, 5, 5); fwd_valid = 1; step();
        end
        fwd_valid = 0; gout_ready = 0; grad_vec = pack(8, 8, 8, 8); grad_valid = 1; step();
        grad_valid = 0;
        #2 rst_n = 0; #1;
        checks++;
        if (gout_valid !== 1'b0 || gout_vec !== '0 || mask_count !== '0) begin
            failures++;
            $display("FAIL async_reset gv=%0b vec=%h cnt=%0d required 0", gout_valid, gout_vec, mask_count);
        end
        step(); step(); rst_n = 1; gout_ready = 1; step();
    endtask

    task automatic test_leaky();
        logic [VW-1:0] exp;
`ifdef RELU_BWD_LEAKY_EN
        exp = pack(10, 80, -10, 2);
`else
        exp = pack(0, 80, 0, 0);
`endif
        fwd_vec = pack(-1, 2, -3, 0); fwd_valid = 1; step();
        fwd_valid = 0; grad_vec = pack(80, 80, -80, 16); grad_valid = 1; step();
        grad_valid = 0;
        @(negedge clk);
        checks++;
        if (gout_valid !== 1'b1 || gout_vec !== exp) begin
            failures++;
            $display("FAIL leaky got=%h required=%h", gout_vec, exp);
        end
        step(); step();
    endtask

    initial begin
        test_reset();
        test_basic();
        idle(); test_backpressure();
        idle(); test_full_empty();
        idle(); test_wrap();
        idle(); test_clr_reset();
        idle(); test_leaky();
        idle(); step(); step();
        checks++;
        if (eq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover entries=%0d required 0", eq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
